// File: rtl/digit_scan_ctrl_if.sv
// Interface between the scan controller and its host/decoder.
// master drives the scan controls and slave drives the select outputs.
interface digit_scan_ctrl_if #(
  parameter int DWELL_W = 16
);
  logic               en;
  logic [DWELL_W-1:0] dwell;
  logic [3:0]         mask;
  logic [1:0]         sel;
  logic               sel_valid;
  logic               frame_done;

  modport master (
    output en, dwell, mask,
    input  sel, sel_valid, frame_done
  );

  modport slave (
    input  en, dwell, mask,
    output sel, sel_valid, frame_done
  );
endinterface

// File: rtl/digit_scan_ctrl.sv
// Sequences a 2-bit select through the enabled positions of a 4-way mux.
// Each slot is a dwell phase, then an optional blanking gap, then an advance.
module digit_scan_ctrl #(
  parameter int DWELL_W   = 16,
  parameter int BLANK_CYC = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  digit_scan_ctrl_if.slave  scan
);

  typedef enum logic [1:0] {IDLE, SHOW, BLANK} state_e;

  localparam logic [7:0] BLANK_LAST = 8'((BLANK_CYC > 0) ? (BLANK_CYC - 1) : 0);

  state_e             state_q, state_d;
  logic [1:0]         sel_q, sel_d;
  logic               valid_q, valid_d;
  logic               frame_q, frame_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [7:0]         blank_q, blank_d;
  logic [1:0]         next_sel;

  function automatic logic [1:0] lowestBit(input logic [3:0] m);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (m[i]) r = 2'(i);
    end
    return r;
  endfunction

  // Circular search from cur+1; offset 4 wraps back to cur itself.
  function automatic logic [1:0] nextBit(input logic [3:0] m, input logic [1:0] cur);
    logic [1:0] r;
    logic [1:0] idx;
    r = cur;
    for (int i = 4; i >= 1; i--) begin
      idx = cur + 2'(i);
      if (m[idx]) r = idx;
    end
    return r;
  endfunction

  assign next_sel = nextBit(scan.mask, sel_q);

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    valid_d = valid_q;
    frame_d = 1'b0;
    dwell_d = dwell_q;
    cnt_d   = cnt_q;
    blank_d = blank_q;

    if (!scan.en || scan.mask == 4'b0000) begin
      state_d = IDLE;
      valid_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = SHOW;
          sel_d   = lowestBit(scan.mask);
          dwell_d = scan.dwell;
          cnt_d   = '0;
          valid_d = 1'b1;
        end
        SHOW: begin
          if (cnt_q != dwell_q) begin
            cnt_d = cnt_q + 1'b1;
          end else if (BLANK_CYC > 0) begin
            state_d = BLANK;
            blank_d = 8'd0;
            valid_d = 1'b0;
          end else begin
            state_d = SHOW;
            sel_d   = next_sel;
            frame_d = (next_sel <= sel_q);
            dwell_d = scan.dwell;
            cnt_d   = '0;
            valid_d = 1'b1;
          end
        end
        BLANK: begin
          if (blank_q != BLANK_LAST) begin
            blank_d = blank_q + 8'd1;
          end else begin
            state_d = SHOW;
            sel_d   = next_sel;
            frame_d = (next_sel <= sel_q);
            dwell_d = scan.dwell;
            cnt_d   = '0;
            valid_d = 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          valid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= 2'd0;
      valid_q <= 1'b0;
      frame_q <= 1'b0;
      dwell_q <= '0;
      cnt_q   <= '0;
      blank_q <= 8'd0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
      frame_q <= frame_d;
      dwell_q <= dwell_d;
      cnt_q   <= cnt_d;
      blank_q <= blank_d;
    end
  end

  assign scan.sel        = sel_q;
  assign scan.sel_valid  = valid_q;
  assign scan.frame_done = frame_q;

endmodule
